// File: rtl/mnist_nn_usb_gpx_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mnist_nn_usb_gpx_irq_ctrl_if
//
// Avalon-MM slave bus bundle for the USB GPX interrupt controller.
//
// Signals:
//   address     2  register select
//   chipselect  1  slave select
//   write_n     1  active-low write strobe
//   writedata  32  write data
//   readdata   32  registered read data (1-cycle latency)
//
// Modports:
//   master  - the Nios II side: drives address/strobes/writedata, samples readdata
//   slave   - the controller:   samples address/strobes/writedata, drives readdata
// ---------------------------------------------------------------------------
interface mnist_nn_usb_gpx_irq_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/mnist_nn_usb_gpx_irq_ctrl.sv
// ---------------------------------------------------------------------------
// mnist_nn_usb_gpx_irq_ctrl
//
// Avalon-MM slave that turns the raw USB GPX status pin into a CPU interrupt.
// The pin is synchronised (two flops), debounced against a programmable
// threshold, edge-qualified according to edge_sel, and latched into a
// write-1-to-clear capture bit. irq is the AND of irq_en and the capture bit.
//
// Parameters:
//   DEBOUNCE_W        width of the debounce counter and threshold register
//   DEBOUNCE_DEFAULT  reset value of the threshold register
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port  raw asynchronous GPX pin
//   irq      level interrupt to the CPU
//
// Register map (unmapped bits read 0):
//   0 RO   bit0 deb, bit1 s2 (synchronised raw level)
//   1 RW   bit0 irq_en, bits2:1 edge_sel (00 rising, 01 falling, 1x both)
//   2 W1C  bit0 cap (writedata[0]=1 clears)
//          [MNIST_NN_GPX_EVENT_CNT_EN] bits31:16 evt, writedata[31]=1 clears
//   3 RW   bits DEBOUNCE_W-1:0 thr (a write also restarts the debounce count)
//
// Optional feature macro: MNIST_NN_GPX_EVENT_CNT_EN
//   Adds a 16-bit saturating counter of qualified edges at addr2[31:16].
//   Without it, addr2[31:16] read 0 and no counter logic exists.
//
// DEBOUNCE_W must not exceed 32 (thr is read back through addr3).
// ---------------------------------------------------------------------------
module mnist_nn_usb_gpx_irq_ctrl #(
    parameter int unsigned DEBOUNCE_W       = 8,
    parameter int unsigned DEBOUNCE_DEFAULT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    mnist_nn_usb_gpx_irq_ctrl_if.slave   bus,
    input  logic                         in_port,
    output logic                         irq
);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_CAP    = 2'd2;
    localparam logic [1:0] ADDR_THR    = 2'd3;

    localparam logic [DEBOUNCE_W-1:0] THR_ONE   = DEBOUNCE_W'(1);
    localparam logic [DEBOUNCE_W-1:0] THR_RESET = DEBOUNCE_W'(DEBOUNCE_DEFAULT);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                  s1_q, s2_q;
    logic                  deb_q, deb_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic [DEBOUNCE_W-1:0] thr_q, thr_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic                  cap_q, cap_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [15:0]           evt_field;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic wr_en;
    logic wr_ctrl, wr_cap, wr_thr;

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign wr_ctrl = wr_en && (bus.address == ADDR_CTRL);
    assign wr_cap  = wr_en && (bus.address == ADDR_CAP);
    assign wr_thr  = wr_en && (bus.address == ADDR_THR);

    // Not every writedata bit lands in a register.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    // -----------------------------------------------------------------------
    // Debounce
    // -----------------------------------------------------------------------
    logic thr_le1;
    logic cnt_done;
    logic deb_upd;

    assign thr_le1  = (thr_q <= THR_ONE);
    // thr_q - 1 only matters when thr_q >= 2, so the wrap at thr_q == 0 is harmless.
    assign cnt_done = thr_le1 || (cnt_q >= (thr_q - THR_ONE));

    always_comb begin
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        deb_upd = 1'b0;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_done) begin
            deb_d   = s2_q;
            cnt_d   = '0;
            deb_upd = 1'b1;
        end else begin
            cnt_d = cnt_q + THR_ONE;
        end
        // A new threshold always starts from a fresh count.
        if (wr_thr) begin
            cnt_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Edge qualification and capture
    // -----------------------------------------------------------------------
    // ctrl_q[2:1] is edge_sel: 00 rising, 01 falling, 1x both.
    logic qual_edge;

    assign qual_edge = deb_upd && (ctrl_q[2] || (ctrl_q[1] ? ~s2_q : s2_q));

    always_comb begin
        cap_d = cap_q;
        if (wr_cap && bus.writedata[0]) begin
            cap_d = 1'b0;
        end
        // A fresh edge outranks a simultaneous clear so no event is lost.
        if (qual_edge) begin
            cap_d = 1'b1;
        end
    end

    assign ctrl_d = wr_ctrl ? bus.writedata[2:0] : ctrl_q;
    assign thr_d  = wr_thr  ? bus.writedata[DEBOUNCE_W-1:0] : thr_q;

    // -----------------------------------------------------------------------
    // Optional event counter
    // -----------------------------------------------------------------------
`ifdef MNIST_NN_GPX_EVENT_CNT_EN
    logic [15:0] evt_q, evt_d;

    always_comb begin
        evt_d = evt_q;
        if (wr_cap && bus.writedata[31]) begin
            // Clear and count on the same edge leaves exactly this one event.
            evt_d = qual_edge ? 16'd1 : 16'd0;
        end else if (qual_edge && (evt_q != 16'hFFFF)) begin
            evt_d = evt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_field = evt_q;
`else
    assign evt_field = 16'h0000;
`endif

    // -----------------------------------------------------------------------
    // Read mux (sampled every edge from pre-write state)
    // -----------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        unique case (bus.address)
            ADDR_STATUS: rdata_d[1:0] = {s2_q, deb_q};
            ADDR_CTRL:   rdata_d[2:0] = ctrl_q;
            ADDR_CAP: begin
                rdata_d[0]     = cap_q;
                rdata_d[31:16] = evt_field;
            end
            ADDR_THR:    rdata_d[DEBOUNCE_W-1:0] = thr_q;
            default:     rdata_d = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            thr_q   <= THR_RESET;
            ctrl_q  <= '0;
            cap_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            s1_q    <= in_port;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            ctrl_q  <= ctrl_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;

    // Pure AND of flops: no decode glitches reach the CPU.
    assign irq = ctrl_q[0] & cap_q;

endmodule

// File: tb/tb_mnist_nn_usb_gpx_irq_ctrl.sv
module tb_mnist_nn_usb_gpx_irq_ctrl;

    logic clk;
    logic reset;
    logic in_port;
    logic irq;

    int unsigned n_vec;
    int unsigned n_miss;

    mnist_nn_usb_gpx_irq_ctrl_if bus_if ();

    mnist_nn_usb_gpx_irq_ctrl #(
        .DEBOUNCE_W       (8),
        .DEBOUNCE_DEFAULT (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus_if.address    = addr;
        bus_if.writedata  = data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus_if.address    = addr;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        tick();
        data              = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    logic [31:0] rd;
    logic        pin;
    logic [31:0] evt5_exp;

    initial begin
        n_vec             = 0;
        n_miss            = 0;
        reset             = 1'b1;
        in_port           = 1'b0;
        pin               = 1'b0;
        bus_if.address    = 2'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
`ifdef MNIST_NN_GPX_EVENT_CNT_EN
        evt5_exp = 32'h0005_0001;
`else
        evt5_exp = 32'h0000_0001;
`endif

        // ---- Reset state ----
        ticks(3);
        check_val("rst_readdata", bus_if.readdata, 32'h0);
        check_val("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        bus_read(2'd0, rd); check_val("rst_addr0", rd, 32'h0);
        bus_read(2'd1, rd); check_val("rst_addr1", rd, 32'h0);
        bus_read(2'd2, rd); check_val("rst_addr2", rd, 32'h0);
        bus_read(2'd3, rd); check_val("rst_addr3", rd, 32'h4);

        // ---- thr=4, rising, irq_en: qualified edge 6 edges after pin change ----
        bus_write(2'd1, 32'h1);
        bus_if.address = 2'd0;
        in_port = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) check_val("rise_irq_e5", {31'b0, irq}, 32'h0);
            if (k == 6) check_val("rise_irq_e6", {31'b0, irq}, 32'h1);
        end
        tick();
        check_val("rise_deb", {31'b0, bus_if.readdata[0]}, 32'h1);
        check_val("rise_s2", {31'b0, bus_if.readdata[1]}, 32'h1);
        bus_read(2'd2, rd); check_val("rise_cap", rd, 32'h1);

        // ---- W1C clears cap and irq ----
        bus_write(2'd2, 32'h1);
        check_val("w1c_irq", {31'b0, irq}, 32'h0);
        bus_read(2'd2, rd); check_val("w1c_cap", rd, 32'h0);

        // Falling edge with rising select must not capture
        in_port = 1'b0;
        ticks(8);
        bus_read(2'd2, rd); check_val("fall_unsel_cap", rd, 32'h0);

        // ---- Glitch of 3 cycles is rejected at thr=4 ----
        in_port = 1'b1;
        ticks(3);
        in_port = 1'b0;
        ticks(6);
        bus_read(2'd0, rd); check_val("glitch_addr0", rd, 32'h0);
        bus_read(2'd2, rd); check_val("glitch_cap", rd, 32'h0);
        check_val("glitch_irq", {31'b0, irq}, 32'h0);

        // ---- Set beats simultaneous W1C (falling select) ----
        bus_write(2'd1, 32'h5);          // both edges, irq_en
        in_port = 1'b1;
        ticks(8);
        check_val("both_rise_irq", {31'b0, irq}, 32'h1);
        bus_write(2'd1, 32'h3);          // falling, irq_en
        in_port = 1'b0;
        ticks(5);
        bus_write(2'd2, 32'h1);          // lands on edge 6, same as the falling edge
        bus_read(2'd2, rd); check_val("setwins_cap", rd, 32'h1);
        check_val("setwins_irq", {31'b0, irq}, 32'h1);
        bus_read(2'd0, rd); check_val("setwins_addr0", rd, 32'h0);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, rd); check_val("late_w1c_cap", rd, 32'h0);
        check_val("late_w1c_irq", {31'b0, irq}, 32'h0);

        // ---- thr=0, both edges, irq masked: deb lags s2 by one edge ----
        bus_write(2'd3, 32'h0);
        bus_write(2'd1, 32'h4);
        bus_read(2'd3, rd); check_val("thr0_readback", rd, 32'h0);
        pin = 1'b0;
        for (int t = 0; t < 4; t++) begin
            pin               = ~pin;
            in_port           = pin;
            bus_if.address    = 2'd0;
            ticks(3);
            check_val("thr0_lag", bus_if.readdata, {30'b0, pin, ~pin});
            tick();
            check_val("thr0_track", bus_if.readdata, {30'b0, pin, pin});
            check_val("thr0_irq_masked", {31'b0, irq}, 32'h0);
            bus_read(2'd2, rd); check_val("thr0_cap", rd, 32'h1);
            bus_write(2'd2, 32'h1);
        end

        // ---- Event counter (reads 0 in the upper half when not built) ----
        bus_write(2'd2, 32'h8000_0001);
        for (int t = 0; t < 5; t++) begin
            pin     = ~pin;
            in_port = pin;
            ticks(4);
        end
        bus_read(2'd2, rd); check_val("evt5", rd, evt5_exp);
        check_val("evt5_irq_masked", {31'b0, irq}, 32'h0);
        bus_write(2'd2, 32'h8000_0001);
        bus_read(2'd2, rd); check_val("evt_clear", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
